// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin sharing of one combinational ALU between two requesters (optional ALU_ARB_STATS_EN adds grant counters)
module alu_arbiter #(
  parameter int DATA_W = 32,
  parameter int OP_W = 4,
  parameter int STAT_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0_valid,
  input  logic [OP_W-1:0]   req0_op,
  input  logic [DATA_W-1:0] req0_a,
  input  logic [DATA_W-1:0] req0_b,
  output logic              req0_ready,
  input  logic              req1_valid,
  input  logic [OP_W-1:0]   req1_op,
  input  logic [DATA_W-1:0] req1_a,
  input  logic [DATA_W-1:0] req1_b,
  output logic              req1_ready,
  output logic [OP_W-1:0]   alu_op,
  output logic [DATA_W-1:0] alu_op1,
  output logic [DATA_W-1:0] alu_op2,
  input  logic [DATA_W-1:0] alu_res,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic              rsp_id,
  output logic [DATA_W-1:0] rsp_data,
`ifdef ALU_ARB_STATS_EN
  input  logic              stat_clr,
  output logic [STAT_W-1:0] grant0_cnt,
  output logic [STAT_W-1:0] grant1_cnt,
`endif
  output logic              busy
);
  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
  state_t state, next_state;
  logic rr_ptr, id_q, grant, idle, accept;
  assign idle = state == IDLE;
  assign grant = (req0_valid && req1_valid) ? rr_ptr : req1_valid;
  assign req0_ready = rst_n && idle && req0_valid && !grant;
  assign req1_ready = rst_n && idle && req1_valid && grant;
  assign accept = req0_ready || req1_ready;
  assign busy = !idle;
  // next state: accept moves to EXEC, EXEC is one cycle, RESP waits for the consumer
  always_comb begin
    next_state = state;
    next_state = idle ? (accept ? EXEC : IDLE) : (state == EXEC) ? RESP : (rsp_ready ? IDLE : RESP);
  end
  // state register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= next_state;
  // ALU operand capture, result capture and round-robin pointer update
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      alu_op <= '0;
      alu_op1 <= '0;
      alu_op2 <= '0;
      id_q <= 1'b0;
      rr_ptr <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_id <= 1'b0;
      rsp_data <= '0;
    end else begin
      if (accept) begin
        alu_op <= grant ? req1_op : req0_op;
        alu_op1 <= grant ? req1_a : req0_a;
        alu_op2 <= grant ? req1_b : req0_b;
        id_q <= grant;
      end
      if (state == EXEC) begin
        rsp_data <= alu_res;
        rsp_id <= id_q;
        rsp_valid <= 1'b1;
      end
      if (state == RESP && rsp_ready) begin
        rsp_valid <= 1'b0;
        rr_ptr <= ~id_q;
      end
    end
`ifdef ALU_ARB_STATS_EN
  // saturating per-port grant counters; clear beats a same-cycle increment
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      grant0_cnt <= '0;
      grant1_cnt <= '0;
    end else if (stat_clr) begin
      grant0_cnt <= '0;
      grant1_cnt <= '0;
    end else begin
      if (req0_ready && !(&grant0_cnt)) grant0_cnt <= grant0_cnt + 1'b1;
      if (req1_ready && !(&grant1_cnt)) grant1_cnt <= grant1_cnt + 1'b1;
    end
`endif
endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: randomized scoreboard bench with a transaction-level round-robin model
module tb_alu_arbiter;
  logic clk = 0, rst_n = 0;
  logic v0 = 0, v1 = 0, r0, r1;
  logic [3:0] op0 = 0, op1 = 0, alu_op;
  logic [31:0] a0 = 0, b0 = 0, a1 = 0, b1 = 0, alu_op1, alu_op2, alu_res, rsp_data;
  logic rsp_valid, rsp_ready = 1, rsp_id, busy;
  logic stat_clr = 0;
  logic [15:0] grant0_cnt, grant1_cnt;
  typedef struct {logic id; logic [31:0] data;} rsp_t;
  rsp_t q[$];
  rsp_t t;
  int total = 0, bad = 0, lat = 99, gc0 = 0, gc1 = 0;
  bit pend = 0, fav = 0, pv = 0, acc, eg, rsp_prev = 0;
  logic pid;
  logic [3:0] e_op = 0;
  logic [31:0] e_a = 0, e_b = 0, pdata;

  always #5 clk = ~clk;

  function automatic logic [31:0] alu_f(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      4'd0: return a + b;
      4'd1: return a - b;
      4'd2: return a & b;
      4'd3: return a | b;
      4'd4: return a ^ b;
      4'd5: return a << b[4:0];
      4'd6: return a >> b[4:0];
      4'd7: return $signed(a) >>> b[4:0];
      4'd8: return {31'b0, $signed(a) < $signed(b)};
      4'd9: return {31'b0, a < b};
      default: return 32'b0;
    endcase
  endfunction

  assign alu_res = alu_f(alu_op, alu_op1, alu_op2);

  alu_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(v0), .req0_op(op0), .req0_a(a0), .req0_b(b0), .req0_ready(r0),
    .req1_valid(v1), .req1_op(op1), .req1_a(a1), .req1_b(b1), .req1_ready(r1),
    .alu_op(alu_op), .alu_op1(alu_op1), .alu_op2(alu_op2), .alu_res(alu_res),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_data(rsp_data),
`ifdef ALU_ARB_STATS_EN
    .stat_clr(stat_clr), .grant0_cnt(grant0_cnt), .grant1_cnt(grant1_cnt),
`endif
    .busy(busy)
  );
`ifndef ALU_ARB_STATS_EN
  assign grant0_cnt = '0;
  assign grant1_cnt = '0;
`endif

  task automatic chk(input string n, input logic [71:0] act, input logic [71:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", n, act, exp);
    end
  endtask

  // monitor: model one transaction at a time, favour the port opposite the last served one
  always @(negedge clk) begin
    if (!rst_n) begin
      chk("reset_ctrl", {busy, rsp_valid, rsp_id, r0, r1, alu_op}, 0);
      chk("reset_data", {rsp_data, alu_op1}, 0);
      chk("reset_op2", alu_op2, 0);
`ifdef ALU_ARB_STATS_EN
      chk("reset_cnt", {grant0_cnt, grant1_cnt}, 0);
`endif
      q.delete();
      pend = 0; fav = 0; pv = 0; lat = 99; gc0 = 0; gc1 = 0;
      e_op = 0; e_a = 0; e_b = 0; rsp_prev = 0;
    end else begin
      eg = (v0 && v1) ? fav : v1;
      acc = !pend && (v0 || v1);
      chk("busy", busy, pend);
      chk("ready0", r0, !pend && v0 && !eg);
      chk("ready1", r1, !pend && v1 && eg);
      chk("alu_inputs", {alu_op, alu_op1, alu_op2}, {e_op, e_a, e_b});
`ifdef ALU_ARB_STATS_EN
      chk("grant_cnt", {grant0_cnt, grant1_cnt}, {gc0[15:0], gc1[15:0]});
      if (stat_clr) begin gc0 = 0; gc1 = 0; end
      else if (acc) begin
        if (!eg && gc0 < 65535) gc0++;
        if (eg && gc1 < 65535) gc1++;
      end
`endif
      lat++;
      if (rsp_valid && !rsp_prev) chk("latency", lat, 2);
      if (pv) chk("rsp_hold", {rsp_valid, rsp_id, rsp_data}, {1'b1, pid, pdata});
      pv = 0;
      if (rsp_valid) begin
        chk("q_depth", q.size(), 1);
        if (q.size() > 0) begin
          chk("rsp", {rsp_id, rsp_data}, {q[0].id, q[0].data});
          if (rsp_ready) begin
            fav = !q[0].id;
            void'(q.pop_front());
            pend = 0;
          end else begin
            pv = 1; pid = rsp_id; pdata = rsp_data;
          end
        end
      end
      if (acc) begin
        e_op = eg ? op1 : op0;
        e_a = eg ? a1 : a0;
        e_b = eg ? b1 : b0;
        t.id = eg;
        t.data = alu_f(e_op, e_a, e_b);
        q.push_back(t);
        pend = 1;
        lat = 0;
      end
      rsp_prev = rsp_valid;
    end
  end

  task automatic issue(input bit p, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    int n = 0;
    bit got = 0;
    if (p) begin v1 = 1; op1 = op; a1 = a; b1 = b; end
    else begin v0 = 1; op0 = op; a0 = a; b0 = b; end
    while (!got && n < 50) begin
      @(negedge clk);
      n++;
      got = p ? r1 : r0;
    end
    chk("issue_accepted", got, 1);
    @(posedge clk); #1;
    if (p) v1 = 0; else v0 = 0;
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    v0 = 1; op0 = 4'd1; a0 = 10; b0 = 3;
    v1 = 1; op1 = 4'd2; a1 = 32'hF0; b1 = 32'h3C;
    cyc(3);
    rst_n = 1;
    cyc(12);
    v0 = 0; v1 = 0;
    cyc(4);
    issue(0, 4'd0, 5, 7);
    cyc(4);
    rsp_ready = 0;
    issue(1, 4'd4, 32'hFF, 32'h0F);
    cyc(7);
    rsp_ready = 1;
    cyc(3);
    issue(1, 4'd3, 32'h1200, 32'h34);
    rst_n = 0;
    cyc(1);
    rst_n = 1;
    v1 = 1; op1 = 4'd9; a1 = 1; b1 = 2;
    issue(0, 4'd1, 100, 1);
    cyc(4);
    v1 = 0;
    cyc(4);
`ifdef ALU_ARB_STATS_EN
    stat_clr = 1;
    cyc(1);
    stat_clr = 0;
    for (int i = 0; i < 5; i++) begin
      issue(i >= 3, 4'(i), 32'(i * 3), 32'd1);
      cyc(2);
    end
    chk("cnt_3_2", {grant0_cnt, grant1_cnt}, {16'd3, 16'd2});
    stat_clr = 1;
    issue(0, 4'd0, 1, 1);
    stat_clr = 0;
    cyc(3);
    chk("cnt_clr", {grant0_cnt, grant1_cnt}, 0);
`endif
    for (int i = 0; i < 400; i++) begin
      v0 = $urandom_range(0, 1) == 1;
      v1 = $urandom_range(0, 1) == 1;
      op0 = 4'($urandom_range(0, 15));
      op1 = 4'($urandom_range(0, 15));
      a0 = $urandom; b0 = $urandom; a1 = $urandom; b1 = $urandom;
      rsp_ready = $urandom_range(0, 3) != 0;
`ifdef ALU_ARB_STATS_EN
      stat_clr = $urandom_range(0, 40) == 0;
`endif
      cyc(1);
    end
    v0 = 0; v1 = 0; rsp_ready = 1; stat_clr = 0;
    cyc(6);
    chk("drained", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
Shares the single RV32I combinational ALU between two requesters: port 0 is the core execute path and port 1 is the address/auxiliary unit. It arbitrates round-robin, registers the granted opcode and operands onto the ALU inputs, captures the ALU result, and returns it through a valid/ready response tagged with the requester ID. Exactly one transaction is in flight at a time.

Parameters:
DATA_W, 32, operand/result width
OP_W, 4, ALU opcode width
STAT_W, 16, statistics counter width (used only with the optional feature)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
req0_valid  in  1  requester 0 has an operation
req0_op  in  OP_W  requester 0 opcode
req0_a  in  DATA_W  requester 0 operand 1
req0_b  in  DATA_W  requester 0 operand 2
req0_ready  out  1  requester 0 accepted this cycle
req1_valid / req1_op / req1_a / req1_b / req1_ready  same as port 0, for requester 1
alu_op  out  OP_W  registered opcode to ALU
alu_op1  out  DATA_W  registered operand 1 to ALU
alu_op2  out  DATA_W  registered operand 2 to ALU
alu_res  in  DATA_W  combinational ALU result
rsp_valid  out  1  result available
rsp_ready  in  1  consumer takes result
rsp_id  out  1  requester that owns rsp_data
rsp_data  out  DATA_W  registered result
busy  out  1  state != IDLE

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous, active-low.
- Reset values:
  - state=IDLE, rr_ptr=0 (port 0 favoured first).
  - alu_op/alu_op1/alu_op2=0, rsp_valid=0, rsp_id=0, rsp_data=0, busy=0.
  - req*_ready=0 while rst_n=0.
- FSM states: IDLE -> EXEC -> RESP -> IDLE.
- IDLE:
  - grant = only valid port; if both are valid, the port equal to rr_ptr.
  - reqN_ready is combinational and is 1 only in IDLE for the granted port with reqN_valid=1. The other port's ready is 0.
  - On accept (valid & ready): latch op/a/b into alu_op/alu_op1/alu_op2, latch the grant into id_q, go to EXEC.
  - With no valid input, stay in IDLE.
- EXEC (exactly 1 cycle): rsp_data <= alu_res, rsp_id <= id_q, rsp_valid <= 1, go to RESP.
- RESP:
  - Hold rsp_valid, rsp_data and rsp_id stable until rsp_ready=1.
  - On the handshake cycle: rsp_valid <= 0, rr_ptr <= ~id_q, go to IDLE.
  - No accept is possible in the same cycle; both readys are 0.
- Latency:
  - accept edge -> rsp_valid high after 2 clk edges.
  - minimum issue interval 3 cycles (rsp_ready held at 1).
- alu_op/alu_op1/alu_op2 keep the last accepted values until the next accept. They never glitch during EXEC or RESP.
- Opcodes pass through unmodified; undefined opcodes yield whatever the ALU returns (0).
- A requester may drop valid before being granted; no state is retained for it.
- Starvation bound: a continuously valid port is granted within 1 transaction of the other port.
- Reset asserted mid-transaction: the transaction is discarded, no response is issued, and all registers return to reset values immediately.

Optional Feature:
Macro ALU_ARB_STATS_EN.
- Defined: adds outputs grant0_cnt and grant1_cnt (STAT_W each) and input stat_clr.
  - Each counter increments on its port's accept and saturates at all-ones.
  - stat_clr=1 synchronously zeroes both counters; stat_clr wins over a same-cycle increment.
  - Counters reset to 0.
- Undefined: these ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Reset check: hold rst_n=0 with both valids=1 -> all outputs 0, both readys 0. Release reset -> req0_ready=1 in the first IDLE cycle.
- Single request: req0 op=0000, a=5, b=7, rsp_ready=1 -> rsp_valid 2 cycles after accept, rsp_id=0, rsp_data=12, busy low the following cycle.
- Round-robin: both ports continuously valid (port0 op=0001, a=10, b=3; port1 op=0010, a=0xF0, b=0x3C) -> grants alternate 0,1,0,1; results 7 and 0x30; rsp_id alternates.
- Backpressure: rsp_ready=0 for 5 cycles after rsp_valid, on req1 op=0100, a=0xFF, b=0x0F -> rsp_data=0xF0 stable, both readys 0. Then rsp_ready=1 -> IDLE next cycle.
- Reset mid-operation: assert rst_n=0 during EXEC -> rsp_valid never rises. After release, a new req0 completes normally and rr_ptr=0.
- ALU_ARB_STATS_EN: 3 port-0 and 2 port-1 accepts -> grant0_cnt=3, grant1_cnt=2. Then stat_clr=1 coincident with an accept -> both counters 0.
